key_debouncer: RTL and testbench

- Upstream input-conditioning stage for the stopwatch control keys (reset, start/pause, display/stop).
- Synchronises and debounces NUM_KEYS active-low push-buttons.
- Provides per key:
  - a clean debounced level;
  - a one-cycle press pulse;
  - a one-cycle release pulse.
- The stopwatch core acts on release pulses only. It no longer carries per-key delay counters.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/key_debounce_channel.sv | 89 ++++++++
 rtl/key_debouncer.sv | 31 +++
 tb/tb_key_debouncer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path: key channel states,
// key index assignments and the default debounce interval.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_t;

  localparam int unsigned KEY_RESET   = 0;
  localparam int unsigned KEY_START   = 1;
  localparam int unsigned KEY_DISPLAY = 2;

  // 200 ms at 50 MHz
  localparam int unsigned DEFAULT_DELAY_TIME = 10000000;

endpackage

// File: rtl/key_debounce_channel.sv
// Single active-low key: two-flop synchroniser followed by a stability
// counter FSM that emits a registered level and one-cycle press/release pulses.
module key_debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int unsigned DELAY_TIME = DEFAULT_DELAY_TIME,
  parameter int unsigned CNT_WIDTH  = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press_pulse,
  output logic key_release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DELAY_TIME);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  logic                 p;
  key_state_t           state;
  logic [CNT_WIDTH-1:0] cnt;

  assign p = ~sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1             <= 1'b1;
      sync2             <= 1'b1;
      state             <= IDLE;
      cnt               <= '0;
      key_level         <= 1'b0;
      key_press_pulse   <= 1'b0;
      key_release_pulse <= 1'b0;
    end else begin
      sync1             <= key_n;
      sync2             <= sync1;
      key_press_pulse   <= 1'b0;
      key_release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_CHK;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!p) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state           <= HELD;
            cnt             <= '0;
            key_level       <= 1'b1;
            key_press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!p) begin
            state <= REL_CHK;
            cnt   <= CNT_ONE;
          end
        end
        REL_CHK: begin
          if (p) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state             <= IDLE;
            cnt               <= '0;
            key_level         <= 1'b0;
            key_release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS independent active-low push-buttons; one channel per key.
module key_debouncer
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 3,
  parameter int unsigned DELAY_TIME = DEFAULT_DELAY_TIME,
  parameter int unsigned CNT_WIDTH  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .DELAY_TIME (DELAY_TIME),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chan (
      .clk               (clk),
      .reset             (reset),
      .key_n             (key_n[i]),
      .key_level         (key_level[i]),
      .key_press_pulse   (key_press_pulse[i]),
      .key_release_pulse (key_release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DELAY_TIME = 4: a vector table for
// press/release/bounce, then hand-written multi-cycle sequences.
module tb_key_debouncer;

  localparam int unsigned NK = 3;
  localparam int unsigned DT = 4;
  localparam int unsigned CW = 3;
  localparam int          PE = DT + 2;  // edge index of the pulse

  logic          clk;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press_pulse;
  logic [NK-1:0] key_release_pulse;

  int n_checks;
  int n_fail;

  key_debouncer #(
    .NUM_KEYS   (NK),
    .DELAY_TIME (DT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .key_n             (key_n),
    .key_level         (key_level),
    .key_press_pulse   (key_press_pulse),
    .key_release_pulse (key_release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NK-1:0] kn;
    logic          rst;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [NK-1:0] kn, input logic rst,
                              input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                              input logic [NK-1:0] rel);
    vec_t v;
    v.kn = kn; v.rst = rst; v.lvl = lvl; v.prs = prs; v.rel = rel;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string name, input string what,
                     input logic [NK-1:0] got, input logic [NK-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %b expected %b at %0t", name, what, got, exp, $time);
    end
  endtask

  // Drive inputs, advance one edge, check outputs 1 time unit after it.
  task automatic cyc(input string name, input logic [NK-1:0] kn, input logic rst,
                     input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                     input logic [NK-1:0] rel);
    key_n = kn;
    reset = rst;
    @(posedge clk);
    #1;
    cmp(name, "level", key_level, lvl);
    cmp(name, "press", key_press_pulse, prs);
    cmp(name, "release", key_release_pulse, rel);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    key_n    = '1;
    reset    = 1'b1;
    @(negedge clk);

    // Reset, clean press/release on key 0, 3-cycle bounce on key 1.
    add(3'b111, 1'b1, 3'b000, 3'b000, 3'b000);
    add(3'b111, 1'b1, 3'b000, 3'b000, 3'b000);
    for (int e = 0; e < 9; e++)
      add(3'b110, 1'b0, (e >= PE) ? 3'b001 : 3'b000,
          (e == PE) ? 3'b001 : 3'b000, 3'b000);
    for (int e = 0; e < 9; e++)
      add(3'b111, 1'b0, (e < PE) ? 3'b001 : 3'b000, 3'b000,
          (e == PE) ? 3'b001 : 3'b000);
    for (int e = 0; e < 3; e++)  add(3'b101, 1'b0, 3'b000, 3'b000, 3'b000);
    for (int e = 0; e < 10; e++) add(3'b111, 1'b0, 3'b000, 3'b000, 3'b000);

    foreach (tbl[i])
      cyc($sformatf("vec%0d", i), tbl[i].kn, tbl[i].rst, tbl[i].lvl, tbl[i].prs, tbl[i].rel);

    // Two-cycle high glitch while held must not release.
    for (int e = 0; e < 10; e++)
      cyc("glitch_press", 3'b110, 1'b0, (e >= PE) ? 3'b001 : 3'b000,
          (e == PE) ? 3'b001 : 3'b000, 3'b000);
    for (int e = 0; e < 2; e++)  cyc("glitch_hi", 3'b111, 1'b0, 3'b001, 3'b000, 3'b000);
    for (int e = 0; e < 14; e++) cyc("glitch_hold", 3'b110, 1'b0, 3'b001, 3'b000, 3'b000);
    for (int e = 0; e < 10; e++)
      cyc("glitch_rel", 3'b111, 1'b0, (e < PE) ? 3'b001 : 3'b000, 3'b000,
          (e == PE) ? 3'b001 : 3'b000);

    // Keys 0 and 2 together; key 1 untouched.
    for (int e = 0; e < 10; e++)
      cyc("simul_press", 3'b010, 1'b0, (e >= PE) ? 3'b101 : 3'b000,
          (e == PE) ? 3'b101 : 3'b000, 3'b000);
    for (int e = 0; e < 10; e++)
      cyc("simul_rel", 3'b111, 1'b0, (e < PE) ? 3'b101 : 3'b000, 3'b000,
          (e == PE) ? 3'b101 : 3'b000);

    // Reset lands on the edges where the press pulse would have fired.
    for (int e = 0; e < 5; e++) cyc("rst_pre", 3'b110, 1'b0, 3'b000, 3'b000, 3'b000);
    for (int e = 0; e < 2; e++) cyc("rst_mid", 3'b110, 1'b1, 3'b000, 3'b000, 3'b000);
    for (int e = 0; e < 10; e++)
      cyc("rst_redetect", 3'b110, 1'b0, (e >= PE) ? 3'b001 : 3'b000,
          (e == PE) ? 3'b001 : 3'b000, 3'b000);
    for (int e = 0; e < 10; e++)
      cyc("rst_rel", 3'b111, 1'b0, (e < PE) ? 3'b001 : 3'b000, 3'b000,
          (e == PE) ? 3'b001 : 3'b000);

    // Long hold on key 2, then release and a quiet tail.
    for (int e = 0; e < 100; e++)
      cyc("long_hold", 3'b011, 1'b0, (e >= PE) ? 3'b100 : 3'b000,
          (e == PE) ? 3'b100 : 3'b000, 3'b000);
    for (int e = 0; e < 26; e++)
      cyc("long_rel", 3'b111, 1'b0, (e < PE) ? 3'b100 : 3'b000, 3'b000,
          (e == PE) ? 3'b100 : 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
